// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : LED driver with OFF / ON / BLINK / EVENT-stretch modes and a
//            shared tick prescaler. Optional macro LED_RETRIGGER_EN restarts
//            a running stretch on every new event.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int PRESCALE      = 1000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] mode_i,
    input  logic       event_i,
    output logic       led_o,
    output logic       active_o
);

    localparam int MAX_TICKS = (BLINK_TICKS > STRETCH_TICKS) ? BLINK_TICKS : STRETCH_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0] BLINK_LAST   = TICK_W'(BLINK_TICKS - 1);
    localparam logic [TICK_W-1:0] STRETCH_LAST = TICK_W'(STRETCH_TICKS - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_EVENT = 2'b11;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_ON       = 3'd1,
        S_BLINK_HI = 3'd2,
        S_BLINK_LO = 3'd3,
        S_WAIT     = 3'd4,
        S_STRETCH  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PRE_W-1:0]    pre_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_next;
    logic                tick;
    logic                mode_match;
    logic                clear_cnt;
    logic                run_cnt;
    logic                led_next;
    logic                active_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_OFF;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            led_o    <= 1'b0;
            active_o <= 1'b0;
        end else begin
            state    <= state_next;
            pre_cnt  <= pre_next;
            tick_cnt <= tick_next;
            led_o    <= led_next;
            active_o <= active_next;
        end
    end

    always_comb begin
        state_next  = state;
        clear_cnt   = 1'b0;
        run_cnt     = 1'b0;
        mode_match  = 1'b0;
        pre_next    = '0;
        tick_next   = '0;
        tick        = (pre_cnt == PRE_LAST);

        // Each state belongs to exactly one mode; a mismatch means a new mode.
        case (state)
            S_OFF:                  mode_match = (mode_i == MODE_OFF);
            S_ON:                   mode_match = (mode_i == MODE_ON);
            S_BLINK_HI, S_BLINK_LO: mode_match = (mode_i == MODE_BLINK);
            S_WAIT, S_STRETCH:      mode_match = (mode_i == MODE_EVENT);
            default:                mode_match = 1'b0;
        endcase

        if (!mode_match) begin
            clear_cnt = 1'b1;
            case (mode_i)
                MODE_OFF:   state_next = S_OFF;
                MODE_ON:    state_next = S_ON;
                MODE_BLINK: state_next = S_BLINK_HI;
                default:    state_next = S_WAIT;
            endcase
        end else begin
            case (state)
                S_BLINK_HI: begin
                    run_cnt = 1'b1;
                    if (tick && tick_cnt == BLINK_LAST) begin
                        state_next = S_BLINK_LO;
                        clear_cnt  = 1'b1;
                    end
                end
                S_BLINK_LO: begin
                    run_cnt = 1'b1;
                    if (tick && tick_cnt == BLINK_LAST) begin
                        state_next = S_BLINK_HI;
                        clear_cnt  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (event_i) begin
                        state_next = S_STRETCH;
                        clear_cnt  = 1'b1;
                    end
                end
                S_STRETCH: begin
                    run_cnt = 1'b1;
                    if (tick && tick_cnt == STRETCH_LAST) begin
                        state_next = event_i ? S_STRETCH : S_WAIT;
                        clear_cnt  = 1'b1;
                    end
`ifdef LED_RETRIGGER_EN
                    else if (event_i) begin
                        clear_cnt = 1'b1;
                    end
`endif
                end
                default: state_next = state;
            endcase
        end

        // Counters sit at zero outside timed states so every pattern starts aligned.
        if (run_cnt && !clear_cnt) begin
            pre_next  = tick ? '0 : pre_cnt + PRE_W'(1);
            tick_next = tick ? tick_cnt + TICK_W'(1) : tick_cnt;
        end

        led_next    = (state_next == S_ON) || (state_next == S_BLINK_HI) ||
                      (state_next == S_STRETCH);
        active_next = (state_next == S_STRETCH);
    end

endmodule
`default_nettype wire
